// File: rtl/qed_inst_pair_issuer.sv
// Dual-core instruction issuer: one source stream mirrored into two per-core FIFOs.
// Optional legality filter enabled by defining QED_INST_FILTER_EN.

module qed_inst_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [31:0]      wdata,
    input  logic             rdy,
    output logic [31:0]      inst,
    output logic             vld,
    output logic [AW:0]      next_cnt,
    output logic [CNT_W-1:0] issue_cnt
);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [DEPTH-1:0][31:0] mem;
    logic [AW-1:0]          rptr, wptr;
    logic [AW:0]            cnt;
    logic                   pop;

    assign vld  = (cnt != '0);
    assign pop  = vld & rdy;
    assign inst = mem[rptr];

    always_comb begin
        next_cnt = cnt;
        if (push && !pop)
            next_cnt = cnt + (AW+1)'(1);
        else if (!push && pop)
            next_cnt = cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
            rptr      <= '0;
            wptr      <= '0;
            cnt       <= '0;
            issue_cnt <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr      <= rptr + AW'(1);
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            cnt <= next_cnt;
        end
    end
endmodule

module qed_inst_pair_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      inst_in,
    input  logic             inst_in_valid,
    output logic             inst_in_ready,
    output logic [31:0]      cpu0_inst,
    output logic             cpu0_valid,
    input  logic             cpu0_ready,
    output logic [31:0]      cpu1_inst,
    output logic             cpu1_valid,
    input  logic             cpu1_ready,
    output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1,
    output logic             in_sync,
    output logic             illegal_seen
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h00000013;

    logic                        push;
    logic [31:0]                 word;
    logic                        ready_q, sync_q;
    logic [1:0]                  rdy, vld;
    logic [1:0][31:0]            inst;
    logic [1:0][AW:0]            ncnt;
    logic [1:0][CNT_W-1:0]       icnt;

    assign push = inst_in_valid & ready_q;
    assign rdy  = {cpu1_ready, cpu0_ready};

`ifdef QED_INST_FILTER_EN
    logic legal, illegal_q;

    always_comb begin
        legal = 1'b1;
        case (inst_in[6:0])
            7'b0110011: begin
                if (inst_in[14:12] == 3'b000 || inst_in[14:12] == 3'b101)
                    legal = (inst_in[31:25] == 7'b0000000) || (inst_in[31:25] == 7'b0100000);
                else
                    legal = (inst_in[31:25] == 7'b0000000);
            end
            7'b0010011: begin
                if (inst_in[14:12] == 3'b001)
                    legal = (inst_in[31:25] == 7'b0000000);
                else if (inst_in[14:12] == 3'b101)
                    legal = (inst_in[31:25] == 7'b0000000) || (inst_in[31:25] == 7'b0100000);
            end
            default: legal = 1'b1;
        endcase
    end

    assign word = legal ? inst_in : NOP;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) illegal_q <= 1'b0;
        else       illegal_q <= illegal_q | (push & ~legal);
    end
    assign illegal_seen = illegal_q;
`else
    assign word         = inst_in;
    assign illegal_seen = 1'b0;
`endif

    // Both FIFOs share push and data so the streams can never diverge.
    for (genvar g = 0; g < 2; g++) begin : g_core
        qed_inst_pair_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (push),
            .wdata     (word),
            .rdy       (rdy[g]),
            .inst      (inst[g]),
            .vld       (vld[g]),
            .next_cnt  (ncnt[g]),
            .issue_cnt (icnt[g])
        );
    end

    // Ready is registered off next-state counts, so no path from cpuN_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
            sync_q  <= 1'b1;
        end else begin
            ready_q <= (ncnt[0] < FULL) && (ncnt[1] < FULL);
            sync_q  <= (ncnt[0] == ncnt[1]);
        end
    end

    assign inst_in_ready = ready_q;
    assign in_sync       = sync_q;
    assign cpu0_inst     = inst[0];
    assign cpu1_inst     = inst[1];
    assign cpu0_valid    = vld[0];
    assign cpu1_valid    = vld[1];
    assign issue_cnt0    = icnt[0];
    assign issue_cnt1    = icnt[1];
endmodule

// File: tb/tb_qed_inst_pair_issuer.sv
// Randomized bench for qed_inst_pair_issuer against a queue-based reference model.
// Define QED_INST_FILTER_EN for both files to exercise the filter build.
`timescale 1ns/1ps
module tb_qed_inst_pair_issuer;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = 16;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          T4    = 65536 + 5;

    logic              clk, rstn;
    logic [31:0]       inst_in;
    logic              inst_in_valid, inst_in_ready;
    logic [31:0]       cpu0_inst, cpu1_inst;
    logic              cpu0_valid, cpu0_ready, cpu1_valid, cpu1_ready;
    logic [CNT_W-1:0]  issue_cnt0, issue_cnt1;
    logic              in_sync, illegal_seen;

    qed_inst_pair_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .inst_in(inst_in), .inst_in_valid(inst_in_valid), .inst_in_ready(inst_in_ready),
        .cpu0_inst(cpu0_inst), .cpu0_valid(cpu0_valid), .cpu0_ready(cpu0_ready),
        .cpu1_inst(cpu1_inst), .cpu1_valid(cpu1_valid), .cpu1_ready(cpu1_ready),
        .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1),
        .in_sync(in_sync), .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] q0[$], q1[$];
    bit          rdy_m, sync_m, ill_m;
    int unsigned c0, c1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_m(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        if (op == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (op == 7'h13) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] filt_m(input logic [31:0] w);
`ifdef QED_INST_FILTER_EN
        return legal_m(w) ? w : NOP;
`else
        return w;
`endif
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        rdy_m = 1'b0; sync_m = 1'b1; ill_m = 1'b0; c0 = 0; c1 = 0;
    endtask

    task automatic check_state();
        chk("ready", inst_in_ready, rdy_m);
        chk("valid0", cpu0_valid, q0.size() != 0);
        chk("valid1", cpu1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("inst0", cpu0_inst, q0[0]);
        if (q1.size() != 0) chk("inst1", cpu1_inst, q1[0]);
        chk("in_sync", in_sync, sync_m);
        chk("cnt0", issue_cnt0, c0 % 65536);
        chk("cnt1", issue_cnt1, c1 % 65536);
        chk("illegal", illegal_seen, ill_m);
    endtask

    // Called at a negedge: drive, check, advance model, move to next negedge.
    task automatic cyc(input bit v, input logic [31:0] w, input bit r0, input bit r1);
        bit push, p0, p1;
        inst_in_valid = v; inst_in = w; cpu0_ready = r0; cpu1_ready = r1;
        check_state();
        push = v && rdy_m;
        p0   = (q0.size() != 0) && r0;
        p1   = (q1.size() != 0) && r1;
        if (p0) begin void'(q0.pop_front()); c0++; end
        if (p1) begin void'(q1.pop_front()); c1++; end
        if (push) begin
            q0.push_back(filt_m(w));
            q1.push_back(filt_m(w));
`ifdef QED_INST_FILTER_EN
            if (!legal_m(w)) ill_m = 1'b1;
`endif
        end
        rdy_m  = (q0.size() < DEPTH) && (q1.size() < DEPTH);
        sync_m = (q0.size() == q1.size());
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        case ($urandom_range(0, 3))
            0: return r;
            1: return {f7, r[24:7], 7'h33};
            2: return {f7, r[24:7], 7'h13};
            default: return {r[31:7], 7'h13};
        endcase
    endfunction

    initial begin
        rstn = 1'b0; inst_in = '0; inst_in_valid = 1'b0; cpu0_ready = 1'b0; cpu1_ready = 1'b0;
        model_reset();

        // 1: reset
        repeat (3) @(negedge clk);
        check_state();
        chk("rst_inst0", cpu0_inst, NOP);
        chk("rst_inst1", cpu1_inst, NOP);
        rstn = 1'b1;
        cyc(0, '0, 1, 1);
        chk("t1_ready", inst_in_ready, 1);

        // 2: single add through both cores
        cyc(1, 32'h00B50533, 1, 1);
        chk("t2_inst0", cpu0_inst, 32'h00B50533);
        chk("t2_inst1", cpu1_inst, 32'h00B50533);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 1);
        chk("t2_cnt0", issue_cnt0, 1);
        chk("t2_cnt1", issue_cnt1, 1);

        // 3: cpu1 stalled, intake stops at DEPTH
        for (int i = 0; i < 6; i++) cyc(1, rnd_word(), 1, 0);
        chk("t3_ready", inst_in_ready, 0);
        chk("t3_sync", in_sync, 0);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1);
        chk("t3_resync", in_sync, 1);

        // 5: filter case
        cyc(1, 32'h40B52533, 1, 1);
`ifdef QED_INST_FILTER_EN
        chk("t5_inst0", cpu0_inst, NOP);
        chk("t5_inst1", cpu1_inst, NOP);
`else
        chk("t5_inst0", cpu0_inst, 32'h40B52533);
        chk("t5_inst1", cpu1_inst, 32'h40B52533);
`endif
        cyc(0, '0, 1, 1);
`ifdef QED_INST_FILTER_EN
        chk("t5_ill", illegal_seen, 1);
`else
        chk("t5_ill", illegal_seen, 0);
`endif

        // 6: reset with 3 entries queued
        for (int i = 0; i < 3; i++) cyc(1, rnd_word(), 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("t6_v0", cpu0_valid, 0);
        chk("t6_v1", cpu1_valid, 0);
        chk("t6_ready", inst_in_ready, 0);
        chk("t6_sync", in_sync, 1);
        chk("t6_cnt0", issue_cnt0, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, '0, 0, 0);
        chk("t6_ready1", inst_in_ready, 1);
        cyc(1, 32'h00C58633, 0, 0);
        chk("t6_first0", cpu0_inst, 32'h00C58633);
        chk("t6_first1", cpu1_inst, 32'h00C58633);

        // 4: long random run until both issue counters wrap to 5
        for (int n = 0; n < 95000 && !(c0 == T4 && c1 == T4); n++)
            cyc(1, rnd_word(),
                (c0 < T4) && ($urandom_range(0, 31) != 0),
                (c1 < T4) && ($urandom_range(0, 31) != 0));
        chk("t4_cnt0", issue_cnt0, 5);
        chk("t4_cnt1", issue_cnt1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
